// File: rtl/icap_reboot_sequencer_if.sv
// ICAPE2 write-side bus: chip select, read/write strobe and data word.
// The sequencer drives it through the master modport. An ICAP primitive
// wrapper, or a bench, observes it through the slave modport.
interface icap_reboot_sequencer_if;
  logic        icapCsB;
  logic        icapRdWrB;
  logic [31:0] icapData;

  modport master (output icapCsB, output icapRdWrB, output icapData);
  modport slave  (input  icapCsB, input  icapRdWrB, input  icapData);
endinterface

// File: rtl/icap_reboot_sequencer.sv
// icap_reboot_sequencer: issues the ICAPE2 IPROG (warm boot) command sequence.
//
// A reboot request latches the WBSTAR address. The block then waits
// HOLDOFF_CYCLES and writes eight command words, one per clock. After that it
// parks in DONE until reset.
//
// All ICAP outputs are registered. BITSWAP=1 reverses the bits within each
// byte, which is the ICAPE2 bit-ordering convention.
//
// Optional build macro ICAP_REBOOT_ABORT_EN: when it is defined, abortReq
// cancels a pending reboot while the block is in the holdoff wait. Without the
// macro, abortReq is ignored.
module icap_reboot_sequencer #(
  parameter int unsigned HOLDOFF_CYCLES = 16,
  parameter bit          BITSWAP        = 1'b1
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        rebootReq,
  input  logic [31:0] rebootAddress,
  input  logic        abortReq,
  output logic        busy,
  output logic        done,
  icap_reboot_sequencer_if.master icap
);

  localparam int unsigned CNT_W = (HOLDOFF_CYCLES == 0) ? 1 : $clog2(HOLDOFF_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, HOLD, SEQ, DONE} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [2:0]         idx, idx_n;
  logic [31:0]        addr, addr_n;
  logic               busy_q, busy_n;
  logic               done_q, done_n;
  logic               csb_q, csb_n;
  logic               rdwrb_q, rdwrb_n;
  logic [31:0]        data_q, data_n;
  logic               abort;

`ifdef ICAP_REBOOT_ABORT_EN
  assign abort = abortReq;
`else
  logic unused_abort;
  assign abort        = 1'b0;
  assign unused_abort = abortReq;
`endif

  // IPROG command stream; word 4 carries the latched WBSTAR address
  function automatic logic [31:0] cmd_word(input logic [2:0] i, input logic [31:0] a);
    case (i)
      3'd0:    cmd_word = 32'hFFFF_FFFF;
      3'd1:    cmd_word = 32'hAA99_5566;
      3'd2:    cmd_word = 32'h2000_0000;
      3'd3:    cmd_word = 32'h3002_0001;
      3'd4:    cmd_word = a;
      3'd5:    cmd_word = 32'h3000_8001;
      3'd6:    cmd_word = 32'h0000_000F;
      default: cmd_word = 32'h2000_0000;
    endcase
  endfunction

  // Optional per-byte bit reversal applied to every word before it is registered
  function automatic logic [31:0] bus_word(input logic [31:0] w);
    logic [31:0] r;
    r = w;
    if (BITSWAP) begin
      for (int unsigned b = 0; b < 4; b++) begin
        for (int unsigned i = 0; i < 8; i++) begin
          r[8*b + i] = w[8*b + 7 - i];
        end
      end
    end
    return r;
  endfunction

  // State, counters, latched address and registered outputs
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      addr    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      csb_q   <= 1'b1;
      rdwrb_q <= 1'b1;
      data_q  <= '1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      addr    <= addr_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      csb_q   <= csb_n;
      rdwrb_q <= rdwrb_n;
      data_q  <= data_n;
    end
  end

  // Next state and next output values; the outputs are computed one cycle
  // ahead so that each word appears registered in its own cycle
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    addr_n  = addr;
    busy_n  = busy_q;
    done_n  = done_q;
    csb_n   = csb_q;
    rdwrb_n = rdwrb_q;
    data_n  = data_q;
    case (state)
      IDLE: begin
        if (rebootReq) begin
          state_n = HOLD;
          addr_n  = rebootAddress;
          cnt_n   = CNT_W'(HOLDOFF_CYCLES);
          busy_n  = 1'b1;
          rdwrb_n = 1'b0;
        end
      end
      HOLD: begin
        if (abort) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          rdwrb_n = 1'b1;
        end else if (cnt == '0) begin
          state_n = SEQ;
          idx_n   = '0;
          csb_n   = 1'b0;
          data_n  = bus_word(cmd_word(3'd0, addr));
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      SEQ: begin
        if (idx == 3'd7) begin
          state_n = DONE;
          done_n  = 1'b1;
          csb_n   = 1'b1;
          rdwrb_n = 1'b1;
          data_n  = bus_word('1);
        end else begin
          idx_n  = idx + 3'd1;
          data_n = bus_word(cmd_word(idx + 3'd1, addr));
        end
      end
      DONE: begin
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign icap.icapCsB   = csb_q;
  assign icap.icapRdWrB = rdwrb_q;
  assign icap.icapData  = data_q;

endmodule
